hex_display_scan: RTL and testbench

HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

---
 rtl/hex_display_scan.sv | 142 ++++++++++++++
 tb/tb_hex_display_scan.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Eight-digit multiplexed hex display scanner with shadow register, PWM dimming and registered outputs.
// Optional leading-zero blanking is compiled in with `define LEADING_ZERO_BLANK_EN.
module hex_display_scan #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic        enable,
  input  logic [3:0]  bright,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  digit_idx
);

  localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 1);

  logic [31:0] shadow_q, shadow_d;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  pwm_q, pwm_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  slot_nib_q, slot_nib_d;
  logic        slot_dp_q, slot_dp_d;
  logic        capt_pend_q, capt_pend_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
`ifdef LEADING_ZERO_BLANK_EN
  logic        blank_q, blank_d;
`endif

  logic [31:0] src;
  logic        wrap;
  logic        active;
  logic        blank_now;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    src         = load ? data_in : shadow_q;
    shadow_d    = src;
    presc_d     = presc_q;
    pwm_d       = pwm_q;
    idx_d       = idx_q;
    slot_nib_d  = slot_nib_q;
    slot_dp_d   = slot_dp_q;
    capt_pend_d = capt_pend_q;
    an_d        = '1;
    seg_d       = '1;
    dp_d        = 1'b1;
    wrap        = 1'b0;
    active      = 1'b0;
    blank_now   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank_d     = blank_q;
`endif
    if (enable) begin
      wrap        = (presc_q == PRESC_LAST);
      presc_d     = wrap ? '0 : presc_q + 16'd1;
      idx_d       = wrap ? idx_q + 3'd1 : idx_q;
      pwm_d       = pwm_q + 4'd1;
      capt_pend_d = 1'b0;
      // Slot contents follow the next digit index so the new digit is shown on the capture edge itself.
      if (wrap || capt_pend_q) begin
        slot_nib_d = src[{idx_d, 2'b00} +: 4];
        slot_dp_d  = dp_mask[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
        blank_d    = (idx_d != 3'd0) && ((src >> {idx_d, 2'b00}) == '0) && !dp_mask[idx_d];
`endif
      end
`ifdef LEADING_ZERO_BLANK_EN
      blank_now = blank_d;
`endif
      active = (bright == 4'hF) || (pwm_q < bright);
      if (!blank_now) begin
        seg_d = decode(slot_nib_d);
        if (active) an_d = ~(8'b1 << idx_d);
        dp_d = !(slot_dp_d && active);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_q    <= '0;
      presc_q     <= '0;
      pwm_q       <= '0;
      idx_q       <= '0;
      slot_nib_q  <= '0;
      slot_dp_q   <= 1'b0;
      capt_pend_q <= 1'b1;
      an_q        <= '1;
      seg_q       <= '1;
      dp_q        <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q     <= 1'b0;
`endif
    end else begin
      shadow_q    <= shadow_d;
      presc_q     <= presc_d;
      pwm_q       <= pwm_d;
      idx_q       <= idx_d;
      slot_nib_q  <= slot_nib_d;
      slot_dp_q   <= slot_dp_d;
      capt_pend_q <= capt_pend_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q     <= blank_d;
`endif
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed scoreboard bench for hex_display_scan at CLK_DIV=4.
module tb_hex_display_scan;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        load;
  logic        enable;
  logic [3:0]  bright;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  digit_idx;

  hex_display_scan #(.CLK_DIV(4)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .load(load),
    .enable(enable), .bright(bright), .dp_mask(dp_mask),
    .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          k = 0;          // enabled edges since last reset
  logic [31:0] cur_data = '0;  // bench view of the value latched into the slot
  logic [7:0]  cur_dpm = '0;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[n];
  endfunction

  task automatic push_enabled(input string tag);
    exp_t e;
    int   idx;
    logic [3:0] nib;
    logic act, blank;
    k++;
    idx   = (k / 4) % 8;
    nib   = 4'(cur_data >> (idx * 4));
    act   = (bright == 4'hF) || (((k - 1) % 16) < int'(bright));
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx != 0) && ((cur_data >> (idx * 4)) == 32'h0) && !cur_dpm[idx];
`endif
    e.tag = tag;
    e.idx = 3'(idx);
    if (blank) begin
      e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.seg = seg_ref(nib);
      e.an  = act ? ~(8'h01 << idx) : 8'hFF;
      e.dp  = !(cur_dpm[idx] && act);
    end
    sb.push_back(e);
  endtask

  task automatic push_disabled(input string tag);
    exp_t e;
    e.tag = tag; e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.idx = 3'((k / 4) % 8);
    sb.push_back(e);
  endtask

  task automatic push_reset(input string tag);
    exp_t e;
    k = 0;
    e.tag = tag; e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1; e.idx = 3'd0;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clock);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      errors++; $error("FAIL scoreboard_empty got %0d exp >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (an === e.an) else begin
        errors++; $error("FAIL %s an got %h exp %h (k=%0d)", e.tag, an, e.an, k);
      end
      checks++;
      assert (seg === e.seg) else begin
        errors++; $error("FAIL %s seg got %b exp %b (k=%0d)", e.tag, seg, e.seg, k);
      end
      checks++;
      assert (dp === e.dp) else begin
        errors++; $error("FAIL %s dp got %b exp %b (k=%0d)", e.tag, dp, e.dp, k);
      end
      checks++;
      assert (digit_idx === e.idx) else begin
        errors++; $error("FAIL %s digit_idx got %0d exp %0d (k=%0d)", e.tag, digit_idx, e.idx, k);
      end
    end
  endtask

  task automatic step(input string tag);
    push_enabled(tag);
    tick_check();
  endtask

  task automatic step_off(input string tag);
    push_disabled(tag);
    tick_check();
  endtask

  initial begin
    // Reset must win over load and enable in the same cycle.
    reset = 1'b1; load = 1'b1; data_in = 32'hFFFF_FFFF; enable = 1'b1;
    bright = 4'hF; dp_mask = 8'h00;
    #2;
    push_reset("rst_override"); tick_check();
    reset = 1'b0; load = 1'b0;
    step("rst_shadow_zero");

    reset = 1'b1;
    push_reset("rst_again"); tick_check();
    reset = 1'b0; enable = 1'b0; load = 1'b1;
    data_in = 32'h8765_4321; dp_mask = 8'h5A;
    cur_data = 32'h8765_4321; cur_dpm = 8'h5A;
    step_off("load_idle");
    load = 1'b0; enable = 1'b1;

    // Full scan including the 7->0 wrap at 32 enabled edges.
    repeat (40) step("scan");
    repeat (2) step("scan_mid");
    enable = 1'b0;
    repeat (10) step_off("disabled");
    enable = 1'b1;
    repeat (8) step("resume");

    bright = 4'd4;
    repeat (32) step("pwm4");
    bright = 4'd0;
    repeat (16) step("pwm0");
    bright = 4'hF;

    // Next edge is a slot-capture edge: load there must bypass the shadow.
    while (((k + 1) % 4) != 0) step("align");
    load = 1'b1; data_in = 32'hFEDC_BA98; cur_data = 32'hFEDC_BA98;
    step("bypass");
    load = 1'b0;
    repeat (7) step("bypass_hold");

    step("pre_reset");
    reset = 1'b1;
    push_reset("mid_slot_reset"); tick_check();
    reset = 1'b0;

    enable = 1'b0; load = 1'b1; data_in = 32'h0000_00A0; dp_mask = 8'h00;
    cur_data = 32'h0000_00A0; cur_dpm = 8'h00;
    step_off("lzb_load");
    load = 1'b0; enable = 1'b1;
    repeat (32) step("lzb");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
